// File: rtl/acc_cmd_pkg.sv
// acc_cmd_pkg: shared constants and types for the accelerator command endpoint.
//   - Command codes carried in the low byte of header / finish words.
//   - Bit positions of the header fields.
//   - FSM state encoding used by acc_cmd_endpoint.
//   - finish_word(): builds the first word of the finish message.
package acc_cmd_pkg;

    localparam logic [7:0] CMD_EXEC   = 8'h01;
    localparam logic [7:0] CMD_FINISH = 8'h03;

    // Header word layout: [7:0] command, [15:8] argument count, rest ignored.
    localparam int HDR_CMD_LSB   = 0;
    localparam int HDR_CMD_W     = 8;
    localparam int HDR_NARGS_LSB = 8;
    localparam int HDR_NARGS_W   = 8;

    typedef enum logic [2:0] {
        S_HDR,
        S_TID,
        S_ARGS,
        S_DRAIN,
        S_RUN,
        S_FIN0,
        S_FIN1
    } state_t;

    function automatic logic [63:0] finish_word(input logic [7:0] acc_id);
        return {48'h0, acc_id, CMD_FINISH};
    endfunction

endpackage

// File: rtl/acc_cmd_endpoint_if.sv
// acc_cmd_endpoint_if: command streams between the manager and one
// accelerator endpoint.
//   cmdin_in_*   : manager -> endpoint command words (valid/ready/data/last)
//   cmdout_out_* : endpoint -> manager finish words (valid/ready/tid/data)
// Modports:
//   master : manager side (drives cmdin, accepts cmdout)
//   slave  : endpoint side (accepts cmdin, drives cmdout)
// Parameter AW is the width of cmdout_out_tid.
interface acc_cmd_endpoint_if #(
    parameter int AW = 4
);
    logic          cmdin_in_tvalid;
    logic          cmdin_in_tready;
    logic [63:0]   cmdin_in_tdata;
    logic          cmdin_in_tlast;

    logic          cmdout_out_tvalid;
    logic          cmdout_out_tready;
    logic [AW-1:0] cmdout_out_tid;
    logic [63:0]   cmdout_out_tdata;

    modport master (
        output cmdin_in_tvalid,
        output cmdin_in_tdata,
        output cmdin_in_tlast,
        input  cmdin_in_tready,
        input  cmdout_out_tvalid,
        input  cmdout_out_tid,
        input  cmdout_out_tdata,
        output cmdout_out_tready
    );

    modport slave (
        input  cmdin_in_tvalid,
        input  cmdin_in_tdata,
        input  cmdin_in_tlast,
        output cmdin_in_tready,
        output cmdout_out_tvalid,
        output cmdout_out_tid,
        output cmdout_out_tdata,
        input  cmdout_out_tready
    );

endinterface

// File: rtl/acc_arg_regfile.sv
// acc_arg_regfile: MAX_ARGS x 64-bit argument slots, written one slot at a
// time by index, all slots readable in parallel.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears every slot)
//   wr_en     : write strobe
//   wr_idx    : slot index to write (NW bits)
//   wr_data   : 64-bit word to store
//   args      : flattened slots, slot i at [64*i +: 64]
module acc_arg_regfile #(
    parameter int MAX_ARGS = 8,
    parameter int NW       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [NW-1:0]            wr_idx,
    input  logic [63:0]              wr_data,
    output logic [64*MAX_ARGS-1:0]   args
);

    // One register per slot so every output bit can be cleared by reset;
    // a RAM-style array would not support the parallel clear.
    generate
        for (genvar gi = 0; gi < MAX_ARGS; gi++) begin : g_slot
            logic [63:0] slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (wr_en && (wr_idx == NW'(gi))) begin
                    slot_reg <= wr_data;
                end
            end

            assign args[64*gi +: 64] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/acc_cmd_endpoint.sv
// acc_cmd_endpoint: accelerator-side endpoint of the manager command protocol.
// Accepts an execute packet (header, task id, arguments) on cmdin, starts the
// accelerator, waits for acc_done and returns a two-word finish message on
// cmdout (finish code word, then the task id).
// Ports:
//   aclk, rst      : clock, asynchronous active-high reset
//   cmd            : acc_cmd_endpoint_if.slave (cmdin / cmdout streams)
//   acc_start      : one-cycle start pulse
//   acc_task_id    : latched task id
//   acc_nargs      : number of arguments actually stored
//   acc_args       : argument slots, arg i at [64*i +: 64]
//   acc_done       : task completion, only looked at while running
//   busy           : high whenever not waiting for a header
//   proto_err      : sticky malformed-packet flag (only when the
//                    ACC_CMD_CHECK_EN macro is defined)
// Configuration macro: ACC_CMD_CHECK_EN enables the protocol checker.
module acc_cmd_endpoint
    import acc_cmd_pkg::*;
#(
    parameter int MAX_ACCS = 16,
    parameter int ACC_ID   = 0,
    parameter int MAX_ARGS = 8,
    localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1,
    localparam int NW = $clog2(MAX_ARGS + 1)
) (
    input  logic                   aclk,
    input  logic                   rst,
    acc_cmd_endpoint_if.slave      cmd,
    output logic                   acc_start,
    output logic [63:0]            acc_task_id,
    output logic [NW-1:0]          acc_nargs,
    output logic [64*MAX_ARGS-1:0] acc_args,
    input  logic                   acc_done,
    output logic                   busy
`ifdef ACC_CMD_CHECK_EN
    ,
    output logic                   proto_err
`endif
);

    state_t        state_reg, state_next;

    logic          in_ready;
    logic          in_xfer;
    logic          in_last;
    logic          out_valid;
    logic          out_xfer;
    logic [63:0]   out_data;

    logic [7:0]    hdr_cmd;
    logic          hdr_is_exec;
    logic          hdr_accept;

    logic [NW-1:0] count_reg, count_next;
    logic [NW-1:0] nargs_reg;
    logic          count_full;
    logic          arg_wr;
    logic          run_enter;
    logic          run_first_reg;
    logic [63:0]   task_id_reg;

    assign in_last     = cmd.cmdin_in_tlast;
    assign in_xfer     = cmd.cmdin_in_tvalid & in_ready;
    assign out_xfer    = out_valid & cmd.cmdout_out_tready;
    assign hdr_cmd     = cmd.cmdin_in_tdata[HDR_CMD_LSB +: HDR_CMD_W];
    assign hdr_is_exec = (hdr_cmd == CMD_EXEC);
    // A header that opens a real execute packet (not single-word, not foreign)
    assign hdr_accept  = (state_reg == S_HDR) && in_xfer && !in_last && hdr_is_exec;

    assign count_full  = (count_reg == NW'(MAX_ARGS));
    assign arg_wr      = (state_reg == S_ARGS) && in_xfer && !count_full;
    assign run_enter   = (state_next == S_RUN) && (state_reg != S_RUN);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_reg <= S_HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HDR: begin
                if (in_xfer) begin
                    if (in_last) begin
                        state_next = S_HDR;
                    end else if (!hdr_is_exec) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_TID;
                    end
                end
            end
            S_TID: begin
                if (in_xfer) begin
                    state_next = in_last ? S_RUN : S_ARGS;
                end
            end
            S_ARGS: begin
                if (in_xfer && in_last) begin
                    state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (in_xfer && in_last) begin
                    state_next = S_HDR;
                end
            end
            S_RUN: begin
                if (acc_done) begin
                    state_next = S_FIN0;
                end
            end
            S_FIN0: begin
                if (out_xfer) begin
                    state_next = S_FIN1;
                end
            end
            S_FIN1: begin
                if (out_xfer) begin
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        acc_start = 1'b0;
        busy      = (state_reg != S_HDR);
        case (state_reg)
            S_HDR, S_TID, S_ARGS, S_DRAIN: begin
                in_ready = 1'b1;
            end
            S_RUN: begin
                acc_start = run_first_reg;
            end
            S_FIN0: begin
                out_valid = 1'b1;
                out_data  = finish_word(8'(ACC_ID));
            end
            S_FIN1: begin
                out_valid = 1'b1;
                out_data  = task_id_reg;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        count_next = count_reg;
        if (hdr_accept) begin
            count_next = '0;
        end else if (arg_wr) begin
            count_next = count_reg + NW'(1);
        end
    end

    // acc_nargs is loaded only when entering S_RUN so it stays steady while
    // the next packet's header clears the running count.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            nargs_reg     <= '0;
            task_id_reg   <= '0;
            run_first_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            run_first_reg <= run_enter;
            if ((state_reg == S_TID) && in_xfer) begin
                task_id_reg <= cmd.cmdin_in_tdata;
            end
            if (run_enter) begin
                nargs_reg <= count_next;
            end
        end
    end

    acc_arg_regfile #(
        .MAX_ARGS (MAX_ARGS),
        .NW       (NW)
    ) u_regfile (
        .clk     (aclk),
        .rst     (rst),
        .wr_en   (arg_wr),
        .wr_idx  (count_reg),
        .wr_data (cmd.cmdin_in_tdata),
        .args    (acc_args)
    );

    assign acc_task_id           = task_id_reg;
    assign acc_nargs             = nargs_reg;
    assign cmd.cmdin_in_tready   = in_ready;
    assign cmd.cmdout_out_tvalid = out_valid;
    assign cmd.cmdout_out_tdata  = out_data;
    assign cmd.cmdout_out_tid    = AW'(ACC_ID);

`ifdef ACC_CMD_CHECK_EN
    // ------------------------------------------------------ protocol check
    logic [7:0] hdr_nargs;
    logic [7:0] exp_nargs_reg;
    logic       drop_seen_reg;
    logic       drop_now;
    logic       err_now;
    logic       proto_err_reg;

    assign hdr_nargs = cmd.cmdin_in_tdata[HDR_NARGS_LSB +: HDR_NARGS_W];
    assign drop_now  = (state_reg == S_ARGS) && in_xfer && count_full;

    // Once a word has been dropped the received count exceeds what count_reg
    // can show, so a dropped word at tlast always means a length mismatch.
    always_comb begin
        err_now = 1'b0;
        if ((state_reg == S_HDR) && in_xfer) begin
            err_now = in_last || !hdr_is_exec || (hdr_nargs > 8'(MAX_ARGS));
        end else if ((state_reg == S_TID) && in_xfer && in_last) begin
            err_now = (exp_nargs_reg != 8'd0);
        end else if ((state_reg == S_ARGS) && in_xfer && in_last) begin
            err_now = drop_seen_reg || drop_now || (8'(count_next) != exp_nargs_reg);
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            exp_nargs_reg <= '0;
            drop_seen_reg <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            if (hdr_accept) begin
                exp_nargs_reg <= hdr_nargs;
                drop_seen_reg <= 1'b0;
            end else if (drop_now) begin
                drop_seen_reg <= 1'b1;
            end
            if (err_now) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_reg;
`endif

endmodule

// File: tb/tb_acc_cmd_endpoint.sv
module tb_acc_cmd_endpoint;

    localparam int MAX_ACCS = 16;
    localparam int ACC_ID   = 5;
    localparam int MAX_ARGS = 8;
    localparam int AW       = 4;
    localparam int NW       = 4;

    typedef struct packed {
        logic [NW-1:0]  nargs;
        logic [63:0]    tid;
        logic [511:0]   args;
    } start_t;

    logic                   aclk;
    logic                   rst;
    logic                   acc_start;
    logic [63:0]            acc_task_id;
    logic [NW-1:0]          acc_nargs;
    logic [64*MAX_ARGS-1:0] acc_args;
    logic                   acc_done;
    logic                   busy;
    logic                   proto_err;

    acc_cmd_endpoint_if #(.AW(AW)) cmd ();

    acc_cmd_endpoint #(
        .MAX_ACCS (MAX_ACCS),
        .ACC_ID   (ACC_ID),
        .MAX_ARGS (MAX_ARGS)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .cmd         (cmd),
        .acc_start   (acc_start),
        .acc_task_id (acc_task_id),
        .acc_nargs   (acc_nargs),
        .acc_args    (acc_args),
        .acc_done    (acc_done),
        .busy        (busy)
`ifdef ACC_CMD_CHECK_EN
        ,
        .proto_err   (proto_err)
`endif
    );

`ifndef ACC_CMD_CHECK_EN
    assign proto_err = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          start_cnt = 0;
    int          out_cnt   = 0;
    int          start_cyc = 0;
    int          done_delay = 0;
    logic        prev_start = 1'b0;
    logic        prev_oval  = 1'b0;
    logic [63:0] fin0_word;
    logic [63:0] pkt_q[$];
    logic [63:0] out_q[$];
    start_t      start_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Accelerator model: done pulse done_delay cycles after the start cycle
    initial begin
        acc_done = 1'b0;
        forever begin
            @(negedge aclk);
            if (acc_start && !rst) begin
                repeat (done_delay) @(negedge aclk);
                acc_done = 1'b1;
                @(negedge aclk);
                acc_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        start_t s;
        logic [63:0] w;
        forever begin
            @(negedge aclk);
            if (rst) begin
                prev_start = 1'b0;
                prev_oval  = 1'b0;
            end else begin
                if (prev_start) chk("start_pulse", 64'(acc_start), 64'd0);
                if (acc_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                    $display("start tid=%h nargs=%0d", acc_task_id, acc_nargs);
                    if (start_q.size() == 0) begin
                        chk("unexp_start", 64'd1, 64'd0);
                    end else begin
                        s = start_q.pop_front();
                        chk("nargs", 64'(acc_nargs), 64'(s.nargs));
                        chk("task_id", acc_task_id, s.tid);
                        for (int i = 0; i < int'(s.nargs); i++)
                            chk("arg", acc_args[64*i +: 64], s.args[64*i +: 64]);
                    end
                end
                if (cmd.cmdout_out_tvalid && !prev_oval)
                    chk("lat_fin0", 64'(cyc - start_cyc), 64'(done_delay + 1));
                if (cmd.cmdout_out_tvalid && cmd.cmdout_out_tready) begin
                    out_cnt++;
                    w = cmd.cmdout_out_tdata;
                    $display("out word %h", w);
                    chk("out_tid", 64'(cmd.cmdout_out_tid), 64'(ACC_ID));
                    if (out_q.size() == 0) chk("unexp_out", w, 64'hx);
                    else chk("out_word", w, out_q.pop_front());
                end
                prev_start = acc_start;
                prev_oval  = cmd.cmdout_out_tvalid;
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic l);
        int   n  = 0;
        logic ok = 1'b0;
        cmd.cmdin_in_tvalid = 1'b1;
        cmd.cmdin_in_tdata  = d;
        cmd.cmdin_in_tlast  = l;
        while (!ok && n < 100) begin
            @(negedge aclk);
            ok = cmd.cmdin_in_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        cmd.cmdin_in_tvalid = 1'b0;
        cmd.cmdin_in_tlast  = 1'b0;
        if (!ok) chk("in_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_pkt(input logic exp_start);
        for (int i = 0; i < pkt_q.size(); i++)
            send_word(pkt_q[i], (i == pkt_q.size() - 1));
        if (exp_start) chk("start_lat", 64'(acc_start), 64'd1);
        pkt_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 300 && (out_q.size() != 0 || busy)) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_oval();
        int n = 0;
        while (n < 100 && !cmd.cmdout_out_tvalid) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 100) chk("oval_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_zero(input string tag);
        $display("reset check %s", tag);
        chk({tag, "_start"}, 64'(acc_start), 64'd0);
        chk({tag, "_tid"}, acc_task_id, 64'd0);
        chk({tag, "_nargs"}, 64'(acc_nargs), 64'd0);
        chk({tag, "_args"}, 64'(acc_args != '0), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_oval"}, 64'(cmd.cmdout_out_tvalid), 64'd0);
        chk({tag, "_odata"}, cmd.cmdout_out_tdata, 64'd0);
`ifdef ACC_CMD_CHECK_EN
        chk({tag, "_perr"}, 64'(proto_err), 64'd0);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero(tag);
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        start_t s;
        int sc;
        int oc;
        logic [63:0] hold;

        fin0_word = (64'(ACC_ID) << 8) | 64'h03;
        rst = 1'b1;
        cmd.cmdin_in_tvalid   = 1'b0;
        cmd.cmdin_in_tdata    = '0;
        cmd.cmdin_in_tlast    = 1'b0;
        cmd.cmdout_out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_zero("por");
        rst = 1'b0;
        @(posedge aclk);
        #1;

        // 1: EXEC with two args, done three cycles after start
        done_delay = 3;
        s.nargs = 4'd2; s.tid = 64'hABCD; s.args = '0;
        s.args[63:0] = 64'h11; s.args[127:64] = 64'h22;
        start_q.push_back(s);
        out_q.push_back(fin0_word); out_q.push_back(64'hABCD);
        pkt_q = '{64'h0201, 64'hABCD, 64'h11, 64'h22};
        send_pkt(1'b1);
        wait_idle();
`ifdef ACC_CMD_CHECK_EN
        chk("perr_clean", 64'(proto_err), 64'd0);
`endif

        // 2: EXEC with no args, done in the start cycle
        done_delay = 0;
        s.nargs = 4'd0; s.tid = 64'h5; s.args = '0;
        start_q.push_back(s);
        out_q.push_back(fin0_word); out_q.push_back(64'h5);
        pkt_q = '{64'h0001, 64'h5};
        send_pkt(1'b1);
        wait_idle();

        // 3: ten args announced and sent, only MAX_ARGS kept
        done_delay = 1;
        s.nargs = 4'd8; s.tid = 64'h33; s.args = '0;
        pkt_q.push_back(64'h0A01);
        pkt_q.push_back(64'h33);
        for (int i = 0; i < 10; i++) begin
            pkt_q.push_back(64'h100 + 64'(i));
            if (i < MAX_ARGS) s.args[64*i +: 64] = 64'h100 + 64'(i);
        end
        start_q.push_back(s);
        out_q.push_back(fin0_word); out_q.push_back(64'h33);
        send_pkt(1'b1);
        wait_idle();
`ifdef ACC_CMD_CHECK_EN
        chk("perr_overflow", 64'(proto_err), 64'd1);
`endif

        // 4: foreign command drained, then a normal packet
        sc = start_cnt;
        pkt_q = '{64'h0307, 64'h1, 64'h2, 64'h3};
        send_pkt(1'b0);
        chk("drain_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge aclk);
        #1;
        chk("drain_nostart", 64'(start_cnt), 64'(sc));
        s.nargs = 4'd1; s.tid = 64'h77; s.args = '0; s.args[63:0] = 64'hAA;
        start_q.push_back(s);
        out_q.push_back(fin0_word); out_q.push_back(64'h77);
        pkt_q = '{64'h0101, 64'h77, 64'hAA};
        send_pkt(1'b1);
        wait_idle();

        // 5: cmdout back-pressure for five cycles in S_FIN0
        done_delay = 0;
        cmd.cmdout_out_tready = 1'b0;
        s.nargs = 4'd0; s.tid = 64'h99; s.args = '0;
        start_q.push_back(s);
        out_q.push_back(fin0_word); out_q.push_back(64'h99);
        pkt_q = '{64'h0001, 64'h99};
        send_pkt(1'b1);
        wait_oval();
        hold = cmd.cmdout_out_tdata;
        chk("stall_fin0", hold, fin0_word);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_data", cmd.cmdout_out_tdata, hold);
            chk("stall_inrdy", 64'(cmd.cmdin_in_tready), 64'd0);
        end
        @(posedge aclk);
        #1;
        cmd.cmdout_out_tready = 1'b1;
        oc = out_cnt;
        repeat (2) @(negedge aclk);
        #1;
        chk("fin_2cyc", 64'(out_cnt - oc), 64'd2);
        wait_idle();

        // 6a: reset in the middle of the argument phase
        sc = start_cnt;
        send_word(64'h0301, 1'b0);
        send_word(64'h44, 1'b0);
        send_word(64'h55, 1'b0);
        pulse_reset("rst_args");
        repeat (5) @(posedge aclk);
        #1;
        chk("rst_args_nostart", 64'(start_cnt), 64'(sc));

        // 6b: reset while the second finish word is pending
        cmd.cmdout_out_tready = 1'b0;
        s.nargs = 4'd0; s.tid = 64'h66; s.args = '0;
        start_q.push_back(s);
        out_q.push_back(fin0_word);
        pkt_q = '{64'h0001, 64'h66};
        send_pkt(1'b1);
        wait_oval();
        cmd.cmdout_out_tready = 1'b1;
        @(posedge aclk);
        #1;
        cmd.cmdout_out_tready = 1'b0;
        chk("fin1_valid", 64'(cmd.cmdout_out_tvalid), 64'd1);
        chk("fin1_data", cmd.cmdout_out_tdata, 64'h66);
        pulse_reset("rst_fin1");
        cmd.cmdout_out_tready = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
        chk("outq_empty", 64'(out_q.size()), 64'd0);
        chk("startq_empty", 64'(start_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
